// File: rtl/bp_pkg.sv
// Shared constants, FSM state and update-entry types for the branch-prediction
// update scheduler.
package bp_pkg;

    localparam int BHT_LOWER  = 5;
    localparam int UPD_DEPTH  = 4;
    localparam int STARVE_MAX = 3;

    typedef enum logic {
        NORMAL,
        DRAIN
    } sched_state_t;

    typedef struct packed {
        logic [BHT_LOWER-1:0] addr;
        logic                 taken;
    } upd_entry_t;

endpackage

// File: rtl/branch_update_scheduler_if.sv
// Fetch lookup, execute update and BHT port signals of the update scheduler.
interface branch_update_scheduler_if
    import bp_pkg::*;
#(
    parameter int LOWER = BHT_LOWER
);
    logic             lk_req;
    logic [LOWER-1:0] lk_addr;
    logic             lk_gnt;
    logic             lk_stall;
    logic             pred_valid;
    logic             up_valid;
    logic [LOWER-1:0] up_addr;
    logic             up_taken;
    logic             up_ready;
    logic             flush;
    logic             bht_en;
    logic             bht_we;
    logic [LOWER-1:0] bht_addr;
    logic             bht_taken;

    modport master (
        output lk_req, lk_addr, up_valid, up_addr, up_taken, flush,
        input  lk_gnt, lk_stall, pred_valid, up_ready,
               bht_en, bht_we, bht_addr, bht_taken
    );

    modport slave (
        input  lk_req, lk_addr, up_valid, up_addr, up_taken, flush,
        output lk_gnt, lk_stall, pred_valid, up_ready,
               bht_en, bht_we, bht_addr, bht_taken
    );

endinterface

// File: rtl/bht_update_fifo.sv
// Synchronous FIFO holding resolved-branch updates until the BHT port is free.
module bht_update_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = UPD_DEPTH
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic                     push,
    input  logic                     pop,
    input  upd_entry_t               push_data,
    output upd_entry_t               head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    upd_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/branch_update_scheduler.sv
// Arbitrates the single BHT port between fetch lookups and queued branch updates,
// with starvation aging and a drain mode when the update queue fills.
module branch_update_scheduler
    import bp_pkg::*;
#(
    parameter int LOWER      = BHT_LOWER,
    parameter int DEPTH      = UPD_DEPTH,
    parameter int STARVE_MAX = bp_pkg::STARVE_MAX
) (
    input logic                      clk,
    input logic                      arst_n,
    branch_update_scheduler_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int AGE_W = $clog2(STARVE_MAX + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_MAX);

    sched_state_t     state;
    sched_state_t     state_next;
    upd_entry_t       push_entry;
    upd_entry_t       head;
    logic [LOWER-1:0] head_addr;
    logic [CNT_W-1:0] count;
    logic [AGE_W-1:0] age;
    logic             full;
    logic             empty;
    logic             push;
    logic             issue;
    logic             lk_gnt_c;
    logic             force_upd;
    logic             pred_valid_q;

    assign push_entry = '{addr: bus.up_addr, taken: bus.up_taken};
    assign head_addr  = head.addr;
    assign push       = bus.up_valid && !full;
    assign force_upd  = full || (!empty && (age >= AGE_MAX));

    bht_update_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .arst_n    (arst_n),
        .push      (push),
        .pop       (issue),
        .push_data (push_entry),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    always_comb begin
        lk_gnt_c      = 1'b0;
        issue         = 1'b0;
        bus.bht_en    = 1'b0;
        bus.bht_we    = 1'b0;
        bus.bht_addr  = '0;
        bus.bht_taken = 1'b0;
        if (bus.lk_req && !force_upd && (state == NORMAL)) begin
            lk_gnt_c     = 1'b1;
            bus.bht_en   = 1'b1;
            bus.bht_addr = bus.lk_addr;
        end else if (!empty) begin
            issue         = 1'b1;
            bus.bht_en    = 1'b1;
            bus.bht_we    = 1'b1;
            bus.bht_addr  = head_addr;
            bus.bht_taken = head.taken;
        end
    end

    assign bus.lk_gnt     = lk_gnt_c;
    assign bus.lk_stall   = bus.lk_req && !lk_gnt_c;
    assign bus.up_ready   = !full;
    assign bus.pred_valid = pred_valid_q;

    // A starvation pop leaves the queue non-full with age cleared, so lookup
    // priority resumes at once; only a full queue holds DRAIN until it empties.
    always_comb begin
        state_next = state;
        case (state)
            NORMAL: begin
                if (force_upd && full) state_next = DRAIN;
            end
            DRAIN: begin
                if (empty || (issue && !push && (count == CNT_W'(1))))
                    state_next = NORMAL;
            end
            default: state_next = NORMAL;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) state <= NORMAL;
        else         state <= state_next;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)               age <= '0;
        else if (issue || empty)   age <= '0;
        else if (age < AGE_MAX)    age <= age + AGE_W'(1);
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)        pred_valid_q <= 1'b0;
        else if (bus.flush) pred_valid_q <= 1'b0;
        else                pred_valid_q <= lk_gnt_c;
    end

endmodule

// File: tb/tb_branch_update_scheduler.sv
// Self-checking bench for branch_update_scheduler: per-scenario tasks plus a
// scoreboard of pushed updates compared against each issued BHT write.
module tb_branch_update_scheduler;

    logic clk = 1'b0;
    logic arst_n;
    int   checks = 0;
    int   fails  = 0;

    logic [5:0] exp_q [$];
    logic [5:0] exp_entry;

    localparam logic [11:0] RESET_VEC = 12'b0001_0000_0000;

    branch_update_scheduler_if #(.LOWER(5)) bus ();

    branch_update_scheduler #(
        .LOWER      (5),
        .DEPTH      (4),
        .STARVE_MAX (3)
    ) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] out_vec();
        return {bus.lk_gnt, bus.lk_stall, bus.pred_valid, bus.up_ready,
                bus.bht_en, bus.bht_we, bus.bht_taken, bus.bht_addr};
    endfunction

    task automatic applyStimulus(input logic req, input logic [4:0] la,
                                 input logic uv, input logic [4:0] ua,
                                 input logic ut, input logic fl);
        bus.lk_req   = req;
        bus.lk_addr  = la;
        bus.up_valid = uv;
        bus.up_addr  = ua;
        bus.up_taken = ut;
        bus.flush    = fl;
        if (uv) exp_q.push_back({ua, ut});
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Every issued update must be the oldest pushed one not yet issued.
    always @(negedge clk) begin
        if (arst_n === 1'b1 && bus.bht_en === 1'b1 && bus.bht_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("[TB] FAIL sb_issue: got addr=%0d taken=%0d, required no update",
                         bus.bht_addr, bus.bht_taken);
            end else begin
                exp_entry = exp_q.pop_front();
                if ({bus.bht_addr, bus.bht_taken} !== exp_entry) begin
                    fails++;
                    $display("[TB] FAIL sb_order: got addr=%0d taken=%0d, required addr=%0d taken=%0d",
                             bus.bht_addr, bus.bht_taken, exp_entry[5:1], exp_entry[0]);
                end
            end
        end
    end

    task automatic test_reset();
        arst_n = 1'b0;
        applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        #12;
        checks++;
        if (out_vec() !== RESET_VEC) begin
            fails++;
            $display("[TB] FAIL reset_during: got %b, required %b", out_vec(), RESET_VEC);
        end
        #15;
        arst_n = 1'b1;
        next_cycle();
        @(negedge clk);
        checks++;
        if (out_vec() !== RESET_VEC) begin
            fails++;
            $display("[TB] FAIL reset_after: got %b, required %b", out_vec(), RESET_VEC);
        end
        next_cycle();
    endtask

    task automatic test_idle();
        for (int c = 0; c < 6; c++) begin
            applyStimulus(1'b1, 5'(c + 3), 1'b0, 5'd0, 1'b0, 1'b0);
            @(negedge clk);
            checks++;
            if ({bus.lk_gnt, bus.bht_en, bus.bht_we, bus.bht_addr, bus.pred_valid} !==
                {1'b1, 1'b1, 1'b0, 5'(c + 3), (c > 0)}) begin
                fails++;
                $display("[TB] FAIL idle_c%0d: got gnt=%b en=%b we=%b addr=%0d pv=%b, required 1 1 0 %0d %b",
                         c, bus.lk_gnt, bus.bht_en, bus.bht_we, bus.bht_addr, bus.pred_valid,
                         c + 3, (c > 0));
            end
            next_cycle();
        end
    endtask

    task automatic test_starvation();
        applyStimulus(1'b1, 5'd7, 1'b1, 5'd5, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if ({bus.lk_gnt, bus.bht_we, bus.bht_addr} !== {1'b1, 1'b0, 5'd7}) begin
            fails++;
            $display("[TB] FAIL starve_push: got gnt=%b we=%b addr=%0d, required 1 0 7",
                     bus.lk_gnt, bus.bht_we, bus.bht_addr);
        end
        next_cycle();
        for (int c = 1; c <= 3; c++) begin
            applyStimulus(1'b1, 5'(7 + c), 1'b0, 5'd0, 1'b0, 1'b0);
            @(negedge clk);
            checks++;
            if ({bus.lk_gnt, bus.bht_we, bus.bht_addr} !== {1'b1, 1'b0, 5'(7 + c)}) begin
                fails++;
                $display("[TB] FAIL starve_wait_c%0d: got gnt=%b we=%b addr=%0d, required 1 0 %0d",
                         c, bus.lk_gnt, bus.bht_we, bus.bht_addr, 7 + c);
            end
            next_cycle();
        end
        applyStimulus(1'b1, 5'd11, 1'b0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if ({bus.lk_gnt, bus.lk_stall, bus.bht_we, bus.bht_addr, bus.bht_taken} !==
            {1'b0, 1'b1, 1'b1, 5'd5, 1'b1}) begin
            fails++;
            $display("[TB] FAIL starve_issue: got gnt=%b stall=%b we=%b addr=%0d tk=%b, required 0 1 1 5 1",
                     bus.lk_gnt, bus.lk_stall, bus.bht_we, bus.bht_addr, bus.bht_taken);
        end
        next_cycle();
        applyStimulus(1'b1, 5'd12, 1'b0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.lk_gnt !== 1'b1) begin
            fails++;
            $display("[TB] FAIL starve_resume: got gnt=%b, required 1", bus.lk_gnt);
        end
        next_cycle();
    endtask

    task automatic fill_queue(input string tag);
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b1, 5'(20 + c), 1'b1, 5'(c + 1), c[0], 1'b0);
            @(negedge clk);
            checks++;
            if ({bus.lk_gnt, bus.up_ready} !== 2'b11) begin
                fails++;
                $display("[TB] FAIL %s_push_c%0d: got gnt=%b ready=%b, required 1 1",
                         tag, c, bus.lk_gnt, bus.up_ready);
            end
            next_cycle();
        end
    endtask

    task automatic test_full_drain();
        fill_queue("full");
        for (int c = 4; c < 8; c++) begin
            applyStimulus(1'b1, 5'd20, 1'b0, 5'd0, 1'b0, 1'b0);
            @(negedge clk);
            checks++;
            if ({bus.lk_stall, bus.bht_we, bus.bht_addr, bus.up_ready} !==
                {1'b1, 1'b1, 5'(c - 3), (c != 4)}) begin
                fails++;
                $display("[TB] FAIL full_drain_c%0d: got stall=%b we=%b addr=%0d ready=%b, required 1 1 %0d %b",
                         c, bus.lk_stall, bus.bht_we, bus.bht_addr, bus.up_ready, c - 3, (c != 4));
            end
            next_cycle();
        end
        applyStimulus(1'b1, 5'd21, 1'b0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if ({bus.lk_gnt, bus.bht_addr} !== {1'b1, 5'd21}) begin
            fails++;
            $display("[TB] FAIL full_resume: got gnt=%b addr=%0d, required 1 21",
                     bus.lk_gnt, bus.bht_addr);
        end
        next_cycle();
    endtask

    task automatic test_flush();
        applyStimulus(1'b1, 5'd2, 1'b1, 5'd17, 1'b0, 1'b0);
        next_cycle();
        applyStimulus(1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if ({bus.lk_gnt, bus.pred_valid} !== 2'b11) begin
            fails++;
            $display("[TB] FAIL flush_cycle: got gnt=%b pv=%b, required 1 1", bus.lk_gnt, bus.pred_valid);
        end
        next_cycle();
        applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if ({bus.pred_valid, bus.bht_we, bus.bht_addr} !== {1'b0, 1'b1, 5'd17}) begin
            fails++;
            $display("[TB] FAIL flush_after: got pv=%b we=%b addr=%0d, required 0 1 17",
                     bus.pred_valid, bus.bht_we, bus.bht_addr);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (bus.bht_en !== 1'b0) begin
            fails++;
            $display("[TB] FAIL flush_empty: got en=%b, required 0", bus.bht_en);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        fill_queue("rst");
        applyStimulus(1'b1, 5'd20, 1'b0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if ({bus.bht_we, bus.bht_addr} !== {1'b1, 5'd1}) begin
            fails++;
            $display("[TB] FAIL rst_first_pop: got we=%b addr=%0d, required 1 1", bus.bht_we, bus.bht_addr);
        end
        next_cycle();
        applyStimulus(1'b1, 5'd20, 1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        checks++;
        if ({bus.lk_stall, bus.bht_we, bus.bht_addr} !== {1'b1, 1'b1, 5'd2}) begin
            fails++;
            $display("[TB] FAIL rst_drain: got stall=%b we=%b addr=%0d, required 1 1 2",
                     bus.lk_stall, bus.bht_we, bus.bht_addr);
        end
        bus.lk_req = 1'b0;
        #1;
        arst_n = 1'b0;
        exp_q.delete();
        #1;
        checks++;
        if (out_vec() !== RESET_VEC) begin
            fails++;
            $display("[TB] FAIL rst_immediate: got %b, required %b", out_vec(), RESET_VEC);
        end
        @(negedge clk);
        #2;
        arst_n = 1'b1;
        next_cycle();
        @(negedge clk);
        checks++;
        if (out_vec() !== RESET_VEC) begin
            fails++;
            $display("[TB] FAIL rst_release: got %b, required %b", out_vec(), RESET_VEC);
        end
        next_cycle();
        applyStimulus(1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if ({bus.lk_gnt, bus.bht_we, bus.bht_addr} !== {1'b1, 1'b0, 5'd9}) begin
            fails++;
            $display("[TB] FAIL rst_normal: got gnt=%b we=%b addr=%0d, required 1 0 9",
                     bus.lk_gnt, bus.bht_we, bus.bht_addr);
        end
        next_cycle();
        applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.bht_en !== 1'b0) begin
            fails++;
            $display("[TB] FAIL rst_queue_empty: got en=%b, required 0", bus.bht_en);
        end
        next_cycle();
    endtask

    task automatic test_wrap();
        logic [4:0] prev_addr = '0;
        logic       prev_tk   = 1'b0;
        for (int c = 0; c <= 10; c++) begin
            logic [4:0] a;
            logic       t;
            a = 5'((c * 3 + 1) % 32);
            t = c[0];
            applyStimulus(1'b0, 5'd0, (c < 10), a, t, 1'b0);
            @(negedge clk);
            checks++;
            if (c == 0) begin
                if ({bus.bht_en, bus.up_ready} !== 2'b01) begin
                    fails++;
                    $display("[TB] FAIL wrap_c0: got en=%b ready=%b, required 0 1", bus.bht_en, bus.up_ready);
                end
            end else if ({bus.bht_en, bus.bht_we, bus.bht_addr, bus.bht_taken, bus.up_ready} !==
                         {1'b1, 1'b1, prev_addr, prev_tk, 1'b1}) begin
                fails++;
                $display("[TB] FAIL wrap_c%0d: got en=%b we=%b addr=%0d tk=%b ready=%b, required 1 1 %0d %b 1",
                         c, bus.bht_en, bus.bht_we, bus.bht_addr, bus.bht_taken, bus.up_ready,
                         prev_addr, prev_tk);
            end
            prev_addr = a;
            prev_tk   = t;
            next_cycle();
        end
        @(negedge clk);
        checks++;
        if (bus.bht_en !== 1'b0) begin
            fails++;
            $display("[TB] FAIL wrap_done: got en=%b, required 0", bus.bht_en);
        end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_idle();
        test_starvation();
        test_full_drain();
        test_flush();
        test_reset_mid();
        test_wrap();
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL sb_leftover: got %0d pending updates, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
